fc_vec_builder: RTL
===================

// Module: fc_vec_builder
// PURPOSE
//  Producer side of an FC layer's parallel activation input. Accepts the previous layer's
//  post-ReLU neuron results one per handshake. Requantizes each to WIDTH bits and assembles
//  them into the N_OUT-element vector that drives the next layer's x[0:IN-1]. Presents the
//  vector with a valid/ready handshake. Sits between one layer's neuron/ReLU outputs and the
//  next layer.
// PARAMETERS
//  WIDTH   8            activation width of the next layer's x[] elements (signed)
//  N_OUT   128          elements per vector (= next layer IN)
//  IN_W    WIDTH*2+7    width of incoming ReLU result (WIDTH*2+$clog2(128))
//  SHIFT   7            right-shift applied during requantization
// PORTS
//  clk       in   1              single clock, rising edge
//  rst_n     in   1              synchronous, active-low reset
//  in_valid  in   1              in_data valid
//  in_ready  out  1              block can accept in_data
//  in_data   in   IN_W           ReLU result, treated as two's complement
//  out_valid out  1              out_vec holds a complete vector
//  out_ready in   1              consumer takes out_vec
//  out_vec   out  WIDTH x N_OUT  unpacked array [0:N_OUT-1] of requantized activations
//  out_sat   out  1              >=1 element of the presented vector saturated
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): idx=0, state FILL, out_valid=0, out_sat=0, in_ready=1.
//    out_vec contents are don't-care but zeroed. Reset mid-fill or mid-hold discards the partial
//    or held vector.
//  - Accept when in_valid&&in_ready. The element goes to buf[idx] and idx increments. Element
//    order equals arrival order: the first accepted element becomes out_vec[0].
//  - Requant (comb, fc_requant): if in_data[IN_W-1]=1 -> 0. Otherwise q=in_data>>SHIFT
//    (truncate); q>2**(WIDTH-1)-1 -> 2**(WIDTH-1)-1 and sat flag. Result is non-negative, WIDTH bits.
//  - FSM FILL: in_ready=1, out_valid=0. On accept with idx==N_OUT-1: idx<=0, state<=HOLD, and
//    out_valid=1 on the next cycle (latency: 1 cycle after the last accept).
//  - FSM HOLD: out_valid=1, out_vec and out_sat stable until out_ready. On out_valid&&out_ready:
//    state<=FILL, out_sat cleared for the next vector.
//  - out_sat = OR of the per-element sat flags of the presented vector; it is accumulated during
//    FILL and cleared on entry to FILL.
//  - in_valid is ignored while in_ready=0; no data is lost or duplicated.
//  - in_data may arrive every cycle; the minimum full-vector period is N_OUT cycles plus the
//    hold time.
// CONFIGURATION
//  FC_VEC_DBUF_EN undefined: single buffer. in_ready=0 throughout HOLD, so the best-case
//    throughput is 1 vector per N_OUT+1 cycles.
//  FC_VEC_DBUF_EN defined: two banks.
//   - Filling proceeds into the other bank while one is presented, so in_ready stays 1 in HOLD.
//   - If the fill bank completes while the present bank is still unconsumed, in_ready drops
//     until out handshake.
//   - On out handshake with a full pending bank: swap the same cycle, out_valid stays 1, and
//     out_sat switches to the pending bank's flag.
//   - Last accept and out handshake in the same cycle: the bank becomes pending and is shown
//     next cycle.
// STRUCTURE
//  fc_pkg: typedef enum logic {FILL, HOLD} fc_vec_state_t; function fc_in_w(WIDTH,IN) returns
//   WIDTH*2+$clog2(IN); localparam ACT_MAX helper.
//  Sub-module fc_requant #(WIDTH,IN_W,SHIFT) (a -> q, sat). It is purely combinational and
//   reused by other layer boundaries.
//  Index counter $clog2(N_OUT) bits; buffers are flop arrays (no RAM).
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 for 3 cycles -> in_ready=1, out_valid=0, out_sat=0,
//    no element stored.
//  2 Ramp: N_OUT=128, in_data=k<<7 for k=0..127 back-to-back -> out_vec[k]=k (k<=127),
//    out_valid 1 cycle after last, out_sat=0.
//  3 Saturate/negative: in_data[0]=23'h7FFFFF (neg) -> out_vec[0]=0. in_data[1]=200<<7 ->
//    out_vec[1]=127, out_sat=1. The next vector with no saturation -> out_sat=0.
//  4 Backpressure: keep out_ready=0 for 20 cycles after a vector completes -> out_vec stable,
//    in_ready=0 (single buffer). out_ready=1 -> FILL next cycle, idx restarts at 0.
//  5 Gapped input: random in_valid (50%), out_ready random -> the scoreboard sees every vector
//    in order, with no drop/dup.
//  6 FC_VEC_DBUF_EN: continuous in_valid, out_ready=1 every 64 cycles -> in_ready drops only
//    when both banks full. Last accept coinciding with out handshake -> the new vector appears
//    next cycle.

Source files
------------

// File: rtl/fc_vec_builder_pkg.sv
// Shared types and helpers for the FC vector builder and neighbouring layer boundaries.
//   fc_vec_state_t : builder FSM state (fill the buffer / hold a complete vector)
//   fc_in_w()      : width of a ReLU result entering a layer: 2*WIDTH + log2(IN)
//   fc_act_max()   : largest positive activation representable in a signed WIDTH-bit x[] element
package fc_vec_builder_pkg;

  typedef enum logic {
    StFill,
    StHold
  } fc_vec_state_t;

  function automatic int unsigned fc_in_w(input int unsigned width, input int unsigned n_in);
    return width * 2 + $clog2(n_in);
  endfunction

  function automatic int unsigned fc_act_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fc_vec_builder_if.sv
// Handshake bundle between a layer's ReLU outputs, the vector builder and the next layer.
//   in_valid / in_ready / in_data     : one ReLU result per handshake (producer -> builder)
//   out_valid / out_ready             : complete-vector handshake (builder -> next layer)
//   out_vec[0:N_OUT-1]                : requantized activations, element 0 = first accepted
//   out_sat                           : at least one element of the presented vector clipped
// Modports: slave = builder view, master = surrounding logic / testbench view.
interface fc_vec_builder_if
  import fc_vec_builder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 128,
  parameter int unsigned IN_W  = fc_in_w(WIDTH, N_OUT)
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec [0:N_OUT-1];
  logic             out_sat;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_vec,
    output out_sat
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_vec,
    input  out_sat
  );

endinterface

// File: rtl/fc_vec_builder_requant.sv
// Combinational requantizer from a wide ReLU result to a WIDTH-bit activation.
//   a_i   [IN_W-1:0]  : ReLU result, two's complement
//   q_o   [WIDTH-1:0] : activation in [0, 2**(WIDTH-1)-1]
//   sat_o             : result was clipped to the positive ceiling
// Negative inputs map to 0 without flagging saturation; positive inputs are shifted right
// (truncating) and clipped.
module fc_vec_builder_requant
  import fc_vec_builder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN_W  = fc_in_w(WIDTH, 128),
  parameter int unsigned SHIFT = 7
) (
  input  logic [IN_W-1:0]  a_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sat_o
);

  localparam logic [IN_W-1:0] ActMax = IN_W'(fc_act_max(WIDTH));

  logic [IN_W-1:0] shifted;

  always_comb begin
    shifted = a_i >> SHIFT;
    q_o     = '0;
    sat_o   = 1'b0;
    if (!a_i[IN_W-1]) begin
      if (shifted > ActMax) begin
        q_o   = ActMax[WIDTH-1:0];
        sat_o = 1'b1;
      end else begin
        q_o = shifted[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fc_vec_builder.sv
// FC layer input-vector builder: collects N_OUT requantized ReLU results, one per handshake,
// into a flop buffer and presents them as the next layer's x[0:N_OUT-1] with valid/ready.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; discards any partial or held vector
//   bus   : fc_vec_builder_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/
//           out_vec/out_sat)
// Build option FC_VEC_DBUF_EN: when defined, two banks ping-pong so filling continues while a
// vector is held; otherwise a single buffer and in_ready is low for the whole hold.
module fc_vec_builder
  import fc_vec_builder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 128,
  parameter int unsigned IN_W  = fc_in_w(WIDTH, N_OUT),
  parameter int unsigned SHIFT = 7
) (
  input logic             clk,
  input logic             rst_n,
  fc_vec_builder_if.slave bus
);

  localparam int unsigned    IdxW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_OUT - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  fc_vec_state_t    state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] rq_val;
  logic             rq_sat;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             last;

  fc_vec_builder_requant #(
    .WIDTH (WIDTH),
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .a_i   (bus.in_data),
    .q_o   (rq_val),
    .sat_o (rq_sat)
  );

  assign out_valid     = (state_q == StHold);
  assign accept        = bus.in_valid & in_ready;
  assign last          = (idx_q == IdxLast);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

`ifdef FC_VEC_DBUF_EN

  // fill_bank_q receives incoming elements; the other bank is the presented one.
  // pend_q: the fill bank is complete but the presented bank has not been taken yet.
  logic             fill_bank_q;
  logic             pend_q;
  logic [1:0]       sat_q;
  logic [WIDTH-1:0] vec_q [2][0:N_OUT-1];
  logic             pres_bank;

  assign pres_bank   = ~fill_bank_q;
  assign in_ready    = ~pend_q;
  assign bus.out_sat = out_valid & sat_q[pres_bank];

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      bus.out_vec[i] = vec_q[pres_bank][i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFill;
      idx_q       <= '0;
      fill_bank_q <= 1'b0;
      pend_q      <= 1'b0;
      sat_q       <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_OUT; i++) begin
          vec_q[b][i] <= '0;
        end
      end
    end else begin
      if (accept) begin
        vec_q[fill_bank_q][idx_q] <= rq_val;
        sat_q[fill_bank_q]        <= sat_q[fill_bank_q] | rq_sat;
        idx_q                     <= last ? '0 : idx_q + IdxOne;
      end
      // Flipping fill_bank_q presents the just-completed bank and recycles the free one,
      // whose stale sat flag is cleared here as it starts filling.
      unique case (state_q)
        StFill: begin
          if (accept && last) begin
            state_q            <= StHold;
            fill_bank_q        <= pres_bank;
            sat_q[pres_bank]   <= 1'b0;
          end
        end
        StHold: begin
          if (pend_q) begin
            if (bus.out_ready) begin
              fill_bank_q      <= pres_bank;
              sat_q[pres_bank] <= 1'b0;
              pend_q           <= 1'b0;
            end
          end else if (accept && last) begin
            if (bus.out_ready) begin
              fill_bank_q      <= pres_bank;
              sat_q[pres_bank] <= 1'b0;
            end else begin
              pend_q <= 1'b1;
            end
          end else if (bus.out_ready) begin
            state_q <= StFill;
          end
        end
      endcase
    end
  end

`else

  logic             sat_q;
  logic [WIDTH-1:0] vec_q [0:N_OUT-1];

  assign in_ready    = (state_q == StFill);
  assign bus.out_sat = out_valid & sat_q;

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      bus.out_vec[i] = vec_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFill;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            vec_q[idx_q] <= rq_val;
            sat_q        <= sat_q | rq_sat;
            if (last) begin
              idx_q   <= '0;
              state_q <= StHold;
            end else begin
              idx_q <= idx_q + IdxOne;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_q <= StFill;
            sat_q   <= 1'b0;
          end
        end
      endcase
    end
  end

`endif

endmodule
